matrix_stream_buffer: RTL and testbench

- Parametrised M x N matrix storage block sitting between the matrix BFM interface and the FPU datapath.
- Accepts matrix_pkg-style operations: nop, load and store.
- Load streams M*N elements in row-major order into internal storage. Store streams them back out, row-major or transposed.
- Successor to the fixed 16-bit load/store definitions: generalised in element width and matrix shape, and adds transposed readout, status flags and an error indication.

---
 rtl/matrix_stream_buffer.sv | 172 +++++++++++++++++
 tb/tb_matrix_stream_buffer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_stream_buffer.sv
// matrix_stream_buffer: ROWS x COLS element store between the matrix BFM and
// the FPU datapath. A load op streams a full matrix in row-major order. A
// store op streams it back out in row-major or column-major order.
module matrix_stream_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int ROWS       = 4,
  parameter int COLS       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            op,
  input  logic                  op_valid,
  input  logic                  op_transpose,
  output logic                  op_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
  output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] out_col,
  output logic                  loaded,
  output logic                  done,
  output logic                  error
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_STORE
  } state_t;

  state_t          state, state_next;
  logic [RW-1:0]   row, row_adv;
  logic [CW-1:0]   col, col_adv;
  logic            transpose;
  logic            start_load, start_store, reject;
  logic            in_xfer, out_xfer, last_pos, col_major;

  logic [DATA_WIDTH-1:0] mem [ROWS][COLS];

  assign op_ready  = (state == S_IDLE);
  assign in_ready  = (state == S_LOAD);
  assign out_valid = (state == S_STORE);

  assign in_xfer   = in_ready && in_valid;
  assign out_xfer  = out_valid && out_ready;
  assign last_pos  = (row == ROW_LAST) && (col == COL_LAST);
  assign col_major = out_valid && transpose;

  assign out_row   = row;
  assign out_col   = col;
  // Read straight from the registered indices so consecutive elements need no
  // bubble; gated to zero outside STORE so idle outputs are clean.
  assign out_data  = out_valid ? mem[row][col] : '0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and op decode; rejected ops only flag an error.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    state_next  = state;
    start_load  = 1'b0;
    start_store = 1'b0;
    reject      = 1'b0;
    case (state)
      S_IDLE: begin
        if (op_valid) begin
          case (op)
            OP_LOAD: begin
              start_load = 1'b1;
              state_next = S_LOAD;
            end
            OP_STORE: begin
              if (loaded) begin
                start_store = 1'b1;
                state_next  = S_STORE;
              end else begin
                reject = 1'b1;
              end
            end
            OP_RSVD: reject = 1'b1;
            OP_NOP:  ;
            default: ;
          endcase
        end
      end
      S_LOAD:  if (in_xfer && last_pos) state_next = S_IDLE;
      S_STORE: if (out_xfer && last_pos) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Index stepping: col is the inner index except for a transposed store.
  always_comb begin
    row_adv = row;
    col_adv = col;
    if (col_major) begin
      if (row == ROW_LAST) begin
        row_adv = '0;
        col_adv = (col == COL_LAST) ? '0 : col + CW'(1);
      end else begin
        row_adv = row + RW'(1);
      end
    end else begin
      if (col == COL_LAST) begin
        col_adv = '0;
        row_adv = (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col_adv = col + CW'(1);
      end
    end
  end

  // Control registers: counters, transpose mode, status and pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row       <= '0;
      col       <= '0;
      transpose <= 1'b0;
      loaded    <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (start_load || start_store) begin
        row <= '0;
        col <= '0;
      end else if (in_xfer || out_xfer) begin
        row <= row_adv;
        col <= col_adv;
      end
      if (start_store) transpose <= op_transpose;
      if (start_load) begin
        loaded <= 1'b0;
      end else if (in_xfer && last_pos) begin
        loaded <= 1'b1;
      end
      done  <= (in_xfer || out_xfer) && last_pos;
      error <= reject;
    end
  end

  // Element storage, written during LOAD.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; its contents are only meaningful once
    // loaded is set, and a reset would forbid mapping it onto RAM.
    if (in_xfer) mem[row][col] <= in_data;
  end

endmodule

// File: tb/tb_matrix_stream_buffer.sv
// Self-checking bench for matrix_stream_buffer (4x4, 16-bit). Expected
// store sequences are derived from a plain matrix model filled element by
// element in row-major order.
module tb_matrix_stream_buffer;

  localparam int DW = 16;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int N  = R * C;

  logic          clk;
  logic          rst_n;
  logic [1:0]    op;
  logic          op_valid;
  logic          op_transpose;
  logic          op_ready;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_row;
  logic [1:0]    out_col;
  logic          loaded;
  logic          done;
  logic          error;

  matrix_stream_buffer #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C)) dut (
    .clk(clk), .rst_n(rst_n),
    .op(op), .op_valid(op_valid), .op_transpose(op_transpose), .op_ready(op_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col),
    .loaded(loaded), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] ref_mat  [R][C];
  logic [DW-1:0] load_vals[N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // gap_mode 0: continuous in_valid; 1: random gaps plus ignored ops.
  task automatic do_load(input int gap_mode);
    int idx = 0;
    int cyc = 0;
    op = 2'b01; op_valid = 1'b1;
    step();
    op_valid = 1'b0; op = 2'b00;
    check("load_entry_loaded", loaded, 0);
    check("load_entry_op_ready", op_ready, 0);
    while (idx < N && cyc < 200) begin
      check("load_in_ready", in_ready, 1);
      check("load_no_done", done, 0);
      check("load_no_error", error, 0);
      if (gap_mode != 0) begin
        op = 2'b11; op_valid = 1'b1;
      end
      in_valid = (gap_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      in_data  = in_valid ? load_vals[idx] : DW'($urandom);
      step();
      if (in_valid) begin
        ref_mat[idx / C][idx % C] = load_vals[idx];
        idx++;
      end
      cyc++;
    end
    in_valid = 1'b0; op_valid = 1'b0; op = 2'b00;
    check("load_count", idx, N);
    if (gap_mode == 0) check("load_cycles", cyc, N);
    check("load_done", done, 1);
    check("load_loaded", loaded, 1);
    check("load_exit_in_ready", in_ready, 0);
    check("load_exit_op_ready", op_ready, 1);
    check("load_exit_error", error, 0);
    step();
    check("load_done_pulse", done, 0);
  endtask

  // mode 0: out_ready always 1; 1: pattern 1,0,0,1; 2: random.
  task automatic do_store(input logic tr, input int mode);
    logic [DW-1:0] exp_d[$];
    int exp_r[$];
    int exp_c[$];
    int k = 0;
    int cyc = 0;
    if (tr) begin
      for (int c = 0; c < C; c++)
        for (int r = 0; r < R; r++) begin
          exp_d.push_back(ref_mat[r][c]); exp_r.push_back(r); exp_c.push_back(c);
        end
    end else begin
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) begin
          exp_d.push_back(ref_mat[r][c]); exp_r.push_back(r); exp_c.push_back(c);
        end
    end
    op = 2'b10; op_transpose = tr; op_valid = 1'b1;
    step();
    op_valid = 1'b0; op_transpose = ~tr;
    while (k < N && cyc < 300) begin
      check("store_valid", out_valid, 1);
      check("store_data", out_data, exp_d[k]);
      check("store_row", out_row, exp_r[k]);
      check("store_col", out_col, exp_c[k]);
      check("store_no_done", done, 0);
      if (mode == 2) begin
        op = 2'b01; op_valid = 1'b1;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: out_ready = $urandom_range(0, 1) != 0;
      endcase
      step();
      if (out_ready) k++;
      cyc++;
    end
    out_ready = 1'b0; op_valid = 1'b0; op = 2'b00;
    check("store_count", k, N);
    if (mode == 0) check("store_cycles", cyc, N);
    check("store_done", done, 1);
    check("store_exit_valid", out_valid, 0);
    check("store_loaded", loaded, 1);
    check("store_exit_op_ready", op_ready, 1);
    check("store_exit_in_ready", in_ready, 0);
    step();
    check("store_done_pulse", done, 0);
  endtask

  task automatic do_reject(input logic [1:0] o);
    op = o; op_valid = 1'b1;
    step();
    op_valid = 1'b0; op = 2'b00;
    check("reject_error", error, 1);
    check("reject_op_ready", op_ready, 1);
    check("reject_no_done", done, 0);
    check("reject_in_ready", in_ready, 0);
    check("reject_out_valid", out_valid, 0);
    step();
    check("reject_error_pulse", error, 0);
    check("reject_idle", op_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; op = 2'b00; op_valid = 1'b0; op_transpose = 1'b0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    #3;
    check("rst_op_ready", op_ready, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_col", out_col, 0);
    check("rst_loaded", loaded, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    #9 rst_n = 1'b1;
    step();

    // Store with nothing loaded, then the reserved op.
    do_reject(2'b10);
    do_reject(2'b11);

    // Load with op_valid low, and an explicit nop: no action.
    op = 2'b01; op_valid = 1'b0;
    step();
    check("novalid_in_ready", in_ready, 0);
    op = 2'b00; op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    check("nop_in_ready", in_ready, 0);
    check("nop_error", error, 0);

    // Directed matrix 0x0001..0x0010.
    for (int i = 0; i < N; i++) load_vals[i] = DW'(i + 1);
    do_load(0);
    do_store(1'b0, 0);
    do_store(1'b1, 0);
    do_store(1'b0, 1);
    do_store(1'b1, 1);

    // Random matrix with input gaps and random backpressure.
    for (int i = 0; i < N; i++) load_vals[i] = DW'($urandom);
    do_load(1);
    do_store(1'b0, 2);
    do_store(1'b1, 2);

    // Reset while element 7 of a new load is presented.
    for (int i = 0; i < N; i++) load_vals[i] = DW'($urandom);
    op = 2'b01; op_valid = 1'b1;
    step();
    op_valid = 1'b0; op = 2'b00;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = load_vals[i];
      step();
    end
    in_valid = 1'b1; in_data = load_vals[6];
    #1 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_loaded", loaded, 0);
    check("midrst_done", done, 0);
    check("midrst_op_ready", op_ready, 1);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("midrst_no_done", done, 0);
    check("midrst_still_unloaded", loaded, 0);
    do_reject(2'b10);

    // A fresh full load after the aborted one.
    do_load(0);
    do_store(1'b0, 2);
    do_store(1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
